td4_prog_loader: RTL
====================

# td4_prog_loader

Writable 16×8 program memory for the TD4 CPU, filled over a byte-stream valid/ready interface. It serves the CPU's instruction fetch: CPU `adr` in, `instr` out. It holds the CPU in reset via `cpu_run` until a complete 16-byte image plus checksum has been received and verified. It sits between a host-side byte source (UART receiver, test bench) and the CPU core.

## Interface
Parameters:
- `WORDS`, 16: program words; must equal 2^width of `adr`, fixed at 16 for TD4.
- `AW`, 4: address width.

Ports:
- `clk`  in  1  system clock, all state on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `load_start`  in  1  single-cycle pulse: begin a new image load at address 0
- `load_valid`  in  1  `load_data` holds a byte
- `load_data`  in  8  image byte, or checksum byte after the 16th word
- `load_ready`  out  1  block accepts a byte this cycle
- `adr`  in  4  CPU fetch address
- `instr`  out  8  instruction at `adr`
- `cpu_run`  out  1  high = CPU may execute; connect to CPU reset release
- `error`  out  1  last load failed its checksum
- `busy`  out  1  load in progress (LOAD or CHECK state)

## Operation
- Storage: 16 registers × 8 bits, `mem[0..15]`. Write-only from the load port; read-only from `adr`.
- Read: `instr = mem[adr]`, purely combinational.
- States:
  - IDLE: the reset state.
  - LOAD: receiving the 16 image bytes.
  - CHECK: waiting for the checksum byte.
  - RUN: image verified, CPU running.
  - ERROR: checksum failed.
- Transfer: a byte is taken on a rising edge where `load_valid && load_ready`.
- IDLE / RUN / ERROR + `load_start` → LOAD:
  - write pointer `wp` = 0, running sum `sum` = 0;
  - `cpu_run` = 0, `error` = 0.
- LOAD, on each transfer:
  - `mem[wp] <= load_data`;
  - `sum <= sum + load_data` (mod 256);
  - `wp` increments.
  - After the transfer at `wp` = 15: `wp` wraps to 0 and the state goes to CHECK.
- CHECK, on transfer:
  - byte == `sum` → RUN (`cpu_run` = 1);
  - otherwise → ERROR (`error` = 1, `cpu_run` stays 0).
  - The checksum byte is not written to memory.
- RUN and ERROR are held until the next `load_start` or reset.
- `load_ready` = 1 exactly in LOAD and CHECK. Bytes offered in other states are ignored and leave no side effect.
- `busy` = 1 exactly in LOAD and CHECK.
- `load_start` in LOAD or CHECK:
  - restarts the load (`wp` = 0, `sum` = 0, state LOAD);
  - any byte transferred in the same cycle is discarded;
  - memory words already written keep their new values until overwritten.
- `load_start` has priority over a simultaneous transfer in every state.
- Outputs after reset assertion:
  - `mem` all 0x00, `instr` = 0x00;
  - `cpu_run` = 0, `error` = 0, `load_ready` = 0, `busy` = 0;
  - state IDLE, `wp` = 0, `sum` = 0.
- Reset mid-load abandons the load. The memory clear makes the partial image invisible.

## Timing
- Reset:
  - asynchronous assertion: all state and outputs take their reset values immediately, without waiting for `clk`;
  - deassertion is sampled on the next rising edge.
- `instr`: zero-cycle latency from `adr`. A write at edge N is visible on `instr` after edge N.
- `load_ready` and `busy` rise the cycle after `load_start` is sampled.
- Full load takes at minimum 17 transfer cycles after `load_start`: 16 data + 1 checksum. Back-to-back transfers are allowed every cycle.
- `cpu_run` rises at the edge that accepts a matching checksum. It falls at the edge that samples `load_start`.
- `error` rises at the edge that accepts a mismatching checksum.
- `load_valid` may be deasserted between bytes for any number of cycles. No timeout.
- All outputs except `instr` are registered.

## Test plan
- Reset check:
  - stimulus: assert `reset` low asynchronously between clock edges;
  - response: `instr` = 0x00 for every `adr`, `cpu_run` = 0, `error` = 0, `load_ready` = 0.
- Good load:
  - stimulus: `load_start`, then bytes 0x00..0x0F back-to-back, then checksum 0x78;
  - response: `cpu_run` = 1, `error` = 0, `busy` = 0;
  - `instr` = 0x0N at `adr` = N for all 16 addresses.
- Bad checksum:
  - stimulus: same image, checksum 0x79;
  - response: `error` = 1, `cpu_run` = 0, state ERROR;
  - a further `load_start` clears `error` next cycle.
- Gapped handshake:
  - stimulus: 16 bytes of 0xFF with random `load_valid` gaps, checksum 0xF0;
  - response: RUN reached, all words 0xFF;
  - bytes offered while IDLE before `load_start` leave `mem` unchanged.
- Restart mid-load:
  - stimulus: `load_start` coincident with the 5th transfer; then a full 16-byte image 0xA0..0xAF and correct checksum 0x78;
  - response: the coincident byte is discarded;
  - `mem[0]` = 0xA0 … `mem[15]` = 0xAF, `cpu_run` = 1.
- Reload while running:
  - stimulus: `load_start` in RUN;
  - response: `cpu_run` falls at that edge, `load_ready` high the next cycle;
  - old words remain readable until overwritten.

Source files
------------

// File: rtl/td4_prog_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : td4_prog_loader
// Purpose  : Writable 16x8 program memory for the TD4 CPU. A host streams a
//            16-byte image followed by one checksum byte over a valid/ready
//            byte port. The block holds the CPU in reset (cpu_run low) until
//            the checksum of the received image has been verified. The CPU
//            fetches instructions combinationally through adr/instr.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   1      system clock, rising edge
//   reset      in   1      asynchronous reset, active low
//   load_start in   1      one-cycle pulse: begin a new image load at word 0
//   load_valid in   1      load_data carries a byte
//   load_data  in   8      image byte, or checksum byte after word 15
//   load_ready out  1      a byte is accepted this cycle (LOAD / CHECK)
//   adr        in   AW     CPU fetch address
//   instr      out  8      mem[adr], zero latency
//   cpu_run    out  1      image verified, CPU may execute
//   error      out  1      last load failed its checksum
//   busy       out  1      load in progress (LOAD / CHECK)
// ============================================================================
module td4_prog_loader #(
    parameter int WORDS = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_start,
    input  logic          load_valid,
    input  logic [7:0]    load_data,
    output logic          load_ready,
    input  logic [AW-1:0] adr,
    output logic [7:0]    instr,
    output logic          cpu_run,
    output logic          error,
    output logic          busy
);

    // ------------------------------------------------------------------------
    // Types and constants
    // ------------------------------------------------------------------------
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CHECK = 3'd2,
        ST_RUN   = 3'd3,
        ST_ERROR = 3'd4
    } state_t;

    localparam logic [AW-1:0] c_last_wp = AW'(WORDS - 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t          state_q, state_d;
    logic [AW-1:0]   wp_q, wp_d;
    logic [7:0]      sum_q, sum_d;
    logic [7:0]      mem_q [WORDS];

    logic            load_ready_q, load_ready_d;
    logic            busy_q, busy_d;
    logic            cpu_run_q, cpu_run_d;
    logic            error_q, error_d;

    logic            w_xfer;
    logic            w_mem_we;

    // A byte moves only when the block is advertising ready; ready is a
    // registered copy of "state is LOAD or CHECK", so this is the handshake.
    assign w_xfer = load_valid && load_ready_q;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        wp_d     = wp_q;
        sum_d    = sum_q;
        w_mem_we = 1'b0;

        if (load_start) begin
            // Start wins over any byte offered in the same cycle, in every
            // state; the coincident byte is simply not consumed.
            state_d = ST_LOAD;
            wp_d    = '0;
            sum_d   = '0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (w_xfer) begin
                        w_mem_we = 1'b1;
                        sum_d    = sum_q + load_data;
                        if (wp_q == c_last_wp) begin
                            wp_d    = '0;
                            state_d = ST_CHECK;
                        end else begin
                            wp_d = wp_q + 1'b1;
                        end
                    end
                end
                ST_CHECK: begin
                    // The checksum byte is compared only, never stored.
                    if (w_xfer) begin
                        state_d = (load_data == sum_q) ? ST_RUN : ST_ERROR;
                    end
                end
                default: begin
                    // IDLE, RUN and ERROR hold until the next start pulse;
                    // bytes offered here are ignored.
                end
            endcase
        end
    end

    // Outputs are registered copies of the decoded next state, so they change
    // on the same edge as the state itself.
    always_comb begin
        load_ready_d = (state_d == ST_LOAD) || (state_d == ST_CHECK);
        busy_d       = (state_d == ST_LOAD) || (state_d == ST_CHECK);
        cpu_run_d    = (state_d == ST_RUN);
        error_d      = (state_d == ST_ERROR);
    end

    // ------------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            wp_q         <= '0;
            sum_q        <= '0;
            load_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            cpu_run_q    <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            wp_q         <= wp_d;
            sum_q        <= sum_d;
            load_ready_q <= load_ready_d;
            busy_q       <= busy_d;
            cpu_run_q    <= cpu_run_d;
            error_q      <= error_d;
        end
    end

    // ------------------------------------------------------------------------
    // Program memory. Cleared on reset so an abandoned partial image can never
    // be fetched by the CPU.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < WORDS; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else if (w_mem_we) begin
            mem_q[wp_q] <= load_data;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign instr      = mem_q[adr];
    assign load_ready = load_ready_q;
    assign busy       = busy_q;
    assign cpu_run    = cpu_run_q;
    assign error      = error_q;

endmodule
`default_nettype wire
